ofs_fim_pcie_ss_seg_serializer: RTL and testbench

Parametrised successor to the single-structure per-segment tuser scheme: takes a NUM_SEG-segment PCIe SS AXI-S beat and emits one segment per output beat, in segment order, skipping empty segments. Each segment carries its own header, vendor and last-segment sideband. The block sits between the multi-segment PCIe SS RX shim and single-segment consumers such as header decoders and narrow AFU ports. It buffers one input beat and sustains one segment per cycle with no bubbles between input beats.

---
 rtl/ofs_fim_pcie_ss_shims_pkg.sv | 20 ++
 rtl/ofs_fim_pcie_ss_seg_pick.sv | 23 ++
 rtl/ofs_fim_pcie_ss_seg_serializer.sv | 149 ++++++++++++++
 tb/tb_ofs_fim_pcie_ss_seg_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared definitions for the PCIe SS AXI-S shims: sideband widths and holding-register states.
package ofs_fim_pcie_ss_shims_pkg;

    localparam int unsigned MAX_HDR_WIDTH = 256;

    // Holding-register occupancy, derived from the remaining-segment mask
    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StHold  = 1'b1;

    // Packed t_tuser_seg_p layout, MSB to LSB: vendor, last_segment, hvalid, hdr
    function automatic int unsigned seg_tuser_width(input int unsigned hdr_width,
                                                    input int unsigned vendor_width);
        return vendor_width + 2 + hdr_width;
    endfunction

    function automatic int unsigned seg_hvalid_bit(input int unsigned hdr_width);
        return hdr_width;
    endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_seg_pick.sv
// Lowest-set-bit priority encoder over the remaining-segment mask.
module ofs_fim_pcie_ss_seg_pick #(
    parameter int unsigned NUM_SEG = 2,
    parameter int unsigned IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic [NUM_SEG-1:0] rem_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               last_o
);

    // Scan high to low so the lowest set bit wins
    always_comb begin
        idx_o = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (rem_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign last_o = (rem_i != '0) && ((rem_i & (rem_i - NUM_SEG'(1))) == '0);

endmodule

// File: rtl/ofs_fim_pcie_ss_seg_serializer.sv
// Serialises a multi-segment PCIe SS AXI-S beat into one active segment per output beat.
module ofs_fim_pcie_ss_seg_serializer
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter int unsigned NUM_SEG        = 2,
    parameter int unsigned SEG_DATA_WIDTH = 256,
    parameter int unsigned HDR_WIDTH      = 256,
    parameter int unsigned VENDOR_WIDTH   = 1,
    localparam int unsigned T_SEG_W       = seg_tuser_width(HDR_WIDTH, VENDOR_WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_tvalid,
    output logic                                in_tready,
    input  logic [NUM_SEG*SEG_DATA_WIDTH-1:0]   in_tdata,
    input  logic [NUM_SEG*SEG_DATA_WIDTH/8-1:0] in_tkeep,
    input  logic [NUM_SEG*T_SEG_W-1:0]          in_tuser_seg,
    input  logic                                in_tlast,
    output logic                                out_tvalid,
    input  logic                                out_tready,
    output logic [SEG_DATA_WIDTH-1:0]           out_tdata,
    output logic [SEG_DATA_WIDTH/8-1:0]         out_tkeep,
    output logic [HDR_WIDTH-1:0]                out_hdr,
    output logic                                out_hvalid,
    output logic [VENDOR_WIDTH-1:0]             out_vendor,
    output logic                                out_last_segment,
    output logic                                out_tlast,
    output logic [15:0]                         drop_cnt,
    output logic                                err_empty_last
);

    localparam int unsigned KEEP_W = SEG_DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int unsigned HV_BIT = seg_hvalid_bit(HDR_WIDTH);

    typedef struct packed {
        logic [VENDOR_WIDTH-1:0] vendor;
        logic                    last_segment;
        logic                    hvalid;
        logic [HDR_WIDTH-1:0]    hdr;
    } t_tuser_seg_p;

    logic [NUM_SEG*SEG_DATA_WIDTH-1:0] data_q;
    logic [NUM_SEG*KEEP_W-1:0]         keep_q;
    logic [NUM_SEG*T_SEG_W-1:0]        tuser_q;
    logic                              tlast_q;
    logic [NUM_SEG-1:0]                rem_q, rem_d;
    logic [15:0]                       drop_cnt_q, drop_cnt_d;
    logic                              err_q, err_d;

    logic [NUM_SEG-1:0] act;
    logic [IDX_W-1:0]   idx;
    logic               last_one;
    logic [0:0]         state;
    logic               accept, load, out_fire;
    t_tuser_seg_p       seg_out;

    always_comb begin
        act = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            act[s] = (|in_tkeep[s*KEEP_W +: KEEP_W]) | in_tuser_seg[s*T_SEG_W + HV_BIT];
        end
    end

    ofs_fim_pcie_ss_seg_pick #(
        .NUM_SEG (NUM_SEG),
        .IDX_W   (IDX_W)
    ) u_pick (
        .rem_i  (rem_q),
        .idx_o  (idx),
        .last_o (last_one)
    );

    assign state      = (rem_q != '0) ? StHold : StEmpty;
    assign out_tvalid = (state == StHold);
    assign out_fire   = out_tvalid && out_tready;
    assign accept     = in_tvalid && in_tready;
    assign load       = accept && (act != '0);

    // Accepting while holding is only allowed as the final segment leaves, so no bubble
    always_comb begin
        in_tready = 1'b1;
        case (state)
            StHold:  in_tready = out_tready && last_one;
            default: in_tready = 1'b1;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q;
        if (out_fire) begin
            rem_d = rem_q & ~(NUM_SEG'(1) << idx);
        end
        if (accept) begin
            rem_d = act;
            if (act == '0) begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                err_d = err_q | in_tlast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q  <= in_tdata;
            keep_q  <= in_tkeep;
            tuser_q <= in_tuser_seg;
            tlast_q <= in_tlast;
        end
    end

    always_comb begin
        out_tdata = '0;
        out_tkeep = '0;
        seg_out   = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (idx == IDX_W'(s)) begin
                out_tdata = data_q[s*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
                out_tkeep = keep_q[s*KEEP_W +: KEEP_W];
                seg_out   = tuser_q[s*T_SEG_W +: T_SEG_W];
            end
        end
    end

    assign out_hdr          = seg_out.hdr;
    assign out_hvalid       = seg_out.hvalid;
    assign out_vendor       = seg_out.vendor;
    assign out_last_segment = seg_out.last_segment;
    assign out_tlast        = tlast_q && last_one;
    assign drop_cnt         = drop_cnt_q;
    assign err_empty_last   = err_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_seg_serializer.sv
// Directed scoreboard bench for the segment serializer (4 segments, 128-bit hdr, 4-bit vendor).
module tb_ofs_fim_pcie_ss_seg_serializer;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned HW = 128;
    localparam int unsigned VW = 4;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned TW = HW + VW + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             in_tvalid, in_tready, in_tlast;
    logic [NS*DW-1:0] in_tdata;
    logic [NS*KW-1:0] in_tkeep;
    logic [NS*TW-1:0] in_tuser_seg;
    logic             out_tvalid, out_tready;
    logic [DW-1:0]    out_tdata;
    logic [KW-1:0]    out_tkeep;
    logic [HW-1:0]    out_hdr;
    logic             out_hvalid;
    logic [VW-1:0]    out_vendor;
    logic             out_last_segment, out_tlast;
    logic [15:0]      drop_cnt;
    logic             err_empty_last;

    ofs_fim_pcie_ss_seg_serializer #(
        .NUM_SEG        (NS),
        .SEG_DATA_WIDTH (DW),
        .HDR_WIDTH      (HW),
        .VENDOR_WIDTH   (VW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_tvalid        (in_tvalid),
        .in_tready        (in_tready),
        .in_tdata         (in_tdata),
        .in_tkeep         (in_tkeep),
        .in_tuser_seg     (in_tuser_seg),
        .in_tlast         (in_tlast),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tdata        (out_tdata),
        .out_tkeep        (out_tkeep),
        .out_hdr          (out_hdr),
        .out_hvalid       (out_hvalid),
        .out_vendor       (out_vendor),
        .out_last_segment (out_last_segment),
        .out_tlast        (out_tlast),
        .drop_cnt         (drop_cnt),
        .err_empty_last   (err_empty_last)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [HW-1:0] hdr;
        logic          hv;
        logic [VW-1:0] vend;
        logic          ls;
        logic          tl;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    logic [7:0]    beat_id;
    logic [DW-1:0] b_data [NS];
    logic [KW-1:0] b_keep [NS];
    logic [HW-1:0] b_hdr  [NS];
    logic          b_hv   [NS];
    logic [VW-1:0] b_vend [NS];
    logic          b_ls   [NS];
    logic          b_last;
    logic          last_accept;
    logic          prev_stall;
    logic [170:0]  prev_out;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [NS-1:0] km, input logic [NS-1:0] hm, input logic last);
        logic [VW-1:0] vpat [NS];
        vpat = '{4'hA, 4'h5, 4'hC, 4'h3};
        beat_id++;
        for (int s = 0; s < NS; s++) begin
            b_data[s] = {beat_id, 8'hD0, 8'(s), ~beat_id};
            b_keep[s] = km[s] ? ((s % 2 == 1) ? 4'h7 : 4'hF) : 4'h0;
            b_hdr[s]  = {32'(beat_id), 32'(s), 32'hC0DE_0000 | 32'(s), ~32'(beat_id)};
            b_hv[s]   = hm[s];
            b_vend[s] = vpat[s];
            b_ls[s]   = (s == NS - 1);
            in_tdata[s*DW +: DW]     = b_data[s];
            in_tkeep[s*KW +: KW]     = b_keep[s];
            in_tuser_seg[s*TW +: TW] = {b_vend[s], b_ls[s], b_hv[s], b_hdr[s]};
        end
        b_last   = last;
        in_tlast = last;
    endtask

    task automatic push_beat();
        exp_t e;
        int   last_act = -1;
        for (int s = 0; s < NS; s++) begin
            if ((|b_keep[s]) || b_hv[s]) last_act = s;
        end
        for (int s = 0; s < NS; s++) begin
            if ((|b_keep[s]) || b_hv[s]) begin
                e.data = b_data[s];
                e.keep = b_keep[s];
                e.hdr  = b_hdr[s];
                e.hv   = b_hv[s];
                e.vend = b_vend[s];
                e.ls   = b_ls[s];
                e.tl   = b_last && (s == last_act);
                q.push_back(e);
            end
        end
    endtask

    // One cycle: sample mid-cycle against the scoreboard, then advance past the edge
    task automatic tick();
        exp_t         e;
        logic         exp_rdy;
        logic [170:0] cur;
        @(negedge clk);
        cur = {out_tdata, out_tkeep, out_hdr, out_hvalid, out_vendor, out_last_segment, out_tlast};
        chk("out_tvalid", out_tvalid, q.size() != 0);
        exp_rdy = (q.size() == 0) || (out_tready && q.size() == 1);
        chk("in_tready", in_tready, exp_rdy);
        if (prev_stall) chk("stall_stable", cur, prev_out);
        prev_stall = out_tvalid && !out_tready;
        prev_out   = cur;
        if (out_tvalid && out_tready && q.size() != 0) begin
            e = q.pop_front();
            chk("seg_data", {out_tdata, out_tkeep}, {e.data, e.keep});
            chk("seg_side", {out_hdr, out_hvalid, out_vendor, out_last_segment},
                {e.hdr, e.hv, e.vend, e.ls});
            chk("seg_tlast", out_tlast, e.tl);
        end
        last_accept = in_tvalid && in_tready;
        if (last_accept) push_beat();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NS-1:0] km, input logic [NS-1:0] hm, input logic last);
        build(km, hm, last);
        in_tvalid   = 1'b1;
        last_accept = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_accept) break;
        end
        chk("accept_bound", last_accept, 1'b1);
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        in_tvalid    = 1'b0;
        in_tlast     = 1'b0;
        in_tdata     = '0;
        in_tkeep     = '0;
        in_tuser_seg = '0;
        out_tready   = 1'b1;
        beat_id      = 8'h0;
        b_last       = 1'b0;
        last_accept  = 1'b0;
        prev_stall   = 1'b0;
        prev_out     = '0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_tvalid", out_tvalid, 1'b0);
        chk("rst_in_tready", in_tready, 1'b1);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        chk("rst_err", err_empty_last, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Two active segments with tlast
        send(4'b0011, 4'b0000, 1'b1);
        chk("t1_seg0_tlast", out_tlast, 1'b0);
        tick();
        chk("t1_seg1_tlast", out_tlast, 1'b1);
        chk("t1_seg1_in_tready", in_tready, 1'b1);
        idle(2);

        // Back-to-back sparse beats: seg1, seg3, seg0 with no gap
        send(4'b1010, 4'b0000, 1'b0);
        send(4'b0001, 4'b0000, 1'b1);
        idle(3);

        // Stall for 5 cycles with two segments remaining
        send(4'b0111, 4'b0000, 1'b0);
        tick();
        out_tready = 1'b0;
        repeat (5) tick();
        out_tready = 1'b1;
        idle(3);

        // Stall on the final segment with the next beat waiting
        send(4'b1001, 4'b0000, 1'b1);
        tick();
        out_tready = 1'b0;
        build(4'b0110, 4'b0000, 1'b0);
        in_tvalid = 1'b1;
        repeat (3) tick();
        out_tready = 1'b1;
        send(4'b0110, 4'b0000, 1'b0);
        idle(3);

        // All-empty beats are dropped
        send(4'b0000, 4'b0000, 1'b1);
        chk("drop_cnt_1", drop_cnt, 16'd1);
        chk("err_set", err_empty_last, 1'b1);
        send(4'b0101, 4'b0000, 1'b1);
        idle(3);
        send(4'b0000, 4'b0000, 1'b0);
        chk("drop_cnt_2", drop_cnt, 16'd2);
        chk("err_sticky", err_empty_last, 1'b1);

        // Header-only segment counts as active; vendor/hdr routed per segment
        send(4'b0001, 4'b0100, 1'b1);
        idle(3);
        send(4'b1111, 4'b1111, 1'b0);
        idle(5);

        // Reset while two segments remain
        send(4'b1111, 4'b0000, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_tvalid", out_tvalid, 1'b0);
        chk("midrst_in_tready", in_tready, 1'b1);
        chk("midrst_drop_cnt", drop_cnt, 16'd0);
        chk("midrst_err", err_empty_last, 1'b0);
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        send(4'b1000, 4'b0000, 1'b1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
